// File: rtl/demux1to2_stream_if.sv
// Handshake bundle for demux1to2_stream: one source port and two sink ports.
// The DUT takes the slave view; the source/sink environment takes the master view.
interface demux1to2_stream_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             sel;
    logic             out1_valid;
    logic             out1_ready;
    logic [WIDTH-1:0] out1_data;
    logic             out2_valid;
    logic             out2_ready;
    logic [WIDTH-1:0] out2_data;

    modport slave (
        input  in_valid,
        input  in_data,
        input  sel,
        input  out1_ready,
        input  out2_ready,
        output in_ready,
        output out1_valid,
        output out1_data,
        output out2_valid,
        output out2_data
    );

    modport master (
        output in_valid,
        output in_data,
        output sel,
        output out1_ready,
        output out2_ready,
        input  in_ready,
        input  out1_valid,
        input  out1_data,
        input  out2_valid,
        input  out2_data
    );
endinterface

// File: rtl/demux1to2_stream.sv
// Registered 1-to-2 word-stream demultiplexer with a one-entry register per sink.
// Define DEMUX_COUNT_EN to build the per-sink 16-bit delivery counters.
module demux1to2_stream #(
    parameter int WIDTH = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    demux1to2_stream_if.slave bus,
    output logic [15:0]       cnt1,
    output logic [15:0]       cnt2
);
    logic             full1;
    logic             full2;
    logic [WIDTH-1:0] data1;
    logic [WIDTH-1:0] data2;
    logic             sel_ready;
    logic             accept;
    logic             load1;
    logic             load2;
    logic             deliver1;
    logic             deliver2;

    // Only the selected sink can stall the source.
    assign sel_ready = bus.sel ? (!full2 || bus.out2_ready)
                               : (!full1 || bus.out1_ready);

    assign accept   = bus.in_valid && sel_ready;
    assign load1    = accept && !bus.sel;
    assign load2    = accept && bus.sel;
    assign deliver1 = full1 && bus.out1_ready;
    assign deliver2 = full2 && bus.out2_ready;

    assign bus.in_ready   = sel_ready;
    assign bus.out1_valid = full1;
    assign bus.out1_data  = data1;
    assign bus.out2_valid = full2;
    assign bus.out2_data  = data2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full1 <= 1'b0;
            data1 <= '0;
        end else begin
            full1 <= load1 || (full1 && !deliver1);
            if (load1) begin
                data1 <= bus.in_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full2 <= 1'b0;
            data2 <= '0;
        end else begin
            full2 <= load2 || (full2 && !deliver2);
            if (load2) begin
                data2 <= bus.in_data;
            end
        end
    end

`ifdef DEMUX_COUNT_EN
    logic [15:0] count1;
    logic [15:0] count2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count1 <= 16'h0000;
            count2 <= 16'h0000;
        end else begin
            if (deliver1) begin
                count1 <= count1 + 16'd1;
            end
            if (deliver2) begin
                count2 <= count2 + 16'd1;
            end
        end
    end

    assign cnt1 = count1;
    assign cnt2 = count2;
`else
    assign cnt1 = 16'h0000;
    assign cnt2 = 16'h0000;
`endif
endmodule

// File: tb/tb_demux1to2_stream.sv
// Scoreboard bench for demux1to2_stream: directed stimulus pushes expected
// words per sink; a negedge monitor pops and compares on every delivery.
module tb_demux1to2_stream;
    logic        clk;
    logic        rst_n;
    logic [15:0] cnt1;
    logic [15:0] cnt2;

    int checks = 0;
    int errors = 0;

    logic [31:0] q1[$];
    logic [31:0] q2[$];

    demux1to2_stream_if #(.WIDTH(32)) bus ();

    demux1to2_stream #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave),
        .cnt1  (cnt1),
        .cnt2  (cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] cexp(input int v);
`ifdef DEMUX_COUNT_EN
        return 16'(v);
`else
        return 16'h0000;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one word, wait (bounded) for in_ready, then drop in_valid after acceptance.
    task automatic send(input logic [31:0] d, input logic s);
        int n;
        n = 0;
        if (s) q2.push_back(d);
        else q1.push_back(d);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.sel      = s;
        @(negedge clk);
        while (!bus.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("send_in_ready", {31'd0, bus.in_ready}, 32'd1);
        tick();
        bus.in_valid = 1'b0;
    endtask

    // Monitor: a delivery happens on the next posedge when valid && ready here.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.out1_valid && bus.out1_ready) begin
                if (q1.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sink1_unexpected got %h expected none", bus.out1_data);
                end else begin
                    chk("sink1_data", bus.out1_data, q1.pop_front());
                end
            end
            if (bus.out2_valid && bus.out2_ready) begin
                if (q2.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sink2_unexpected got %h expected none", bus.out2_data);
                end else begin
                    chk("sink2_data", bus.out2_data, q2.pop_front());
                end
            end
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n          = 1'b0;
        bus.in_valid   = 1'b0;
        bus.in_data    = '0;
        bus.sel        = 1'b0;
        bus.out1_ready = 1'b0;
        bus.out2_ready = 1'b0;

        // Reset values
        #2;
        chk("rst_out1_valid", {31'd0, bus.out1_valid}, 32'd0);
        chk("rst_out2_valid", {31'd0, bus.out2_valid}, 32'd0);
        chk("rst_out1_data", bus.out1_data, 32'd0);
        chk("rst_out2_data", bus.out2_data, 32'd0);
        chk("rst_cnt1", {16'd0, cnt1}, 32'd0);
        chk("rst_cnt2", {16'd0, cnt2}, 32'd0);
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        #10;
        rst_n = 1'b1;
        tick();

        // First word into sink 1, held by back-pressure
        send(32'hAAAAAAAA, 1'b0);
        chk("first_out1_valid", {31'd0, bus.out1_valid}, 32'd1);
        chk("first_out1_data", bus.out1_data, 32'hAAAAAAAA);
        chk("first_out2_valid", {31'd0, bus.out2_valid}, 32'd0);

        // Back-pressure isolation: stalled on sink 1, reroute to sink 2
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h55555555;
        bus.sel      = 1'b0;
        @(negedge clk);
        chk("bp_in_ready_sel0", {31'd0, bus.in_ready}, 32'd0);
        bus.sel = 1'b1;
        #1;
        chk("bp_in_ready_sel1", {31'd0, bus.in_ready}, 32'd1);
        q2.push_back(32'h55555555);
        tick();
        bus.in_valid = 1'b0;
        chk("bp_out2_valid", {31'd0, bus.out2_valid}, 32'd1);
        chk("bp_out2_data", bus.out2_data, 32'h55555555);
        chk("bp_out1_data", bus.out1_data, 32'hAAAAAAAA);
        chk("bp_out1_valid", {31'd0, bus.out1_valid}, 32'd1);

        // Drain both sinks in the same cycle
        bus.out1_ready = 1'b1;
        bus.out2_ready = 1'b1;
        tick();
        tick();
        chk("drain_out1_valid", {31'd0, bus.out1_valid}, 32'd0);
        chk("drain_out2_valid", {31'd0, bus.out2_valid}, 32'd0);
        chk("drain_cnt1", {16'd0, cnt1}, {16'd0, cexp(1)});
        chk("drain_cnt2", {16'd0, cnt2}, {16'd0, cexp(1)});

        // Streaming: 8 words alternating sel, one per cycle
        for (int i = 0; i < 8; i++) begin
            logic        s;
            logic [31:0] d;
            s = (i % 2) == 1;
            d = 32'hC0000000 + 32'(i);
            bus.in_valid = 1'b1;
            bus.in_data  = d;
            bus.sel      = s;
            if (s) q2.push_back(d);
            else q1.push_back(d);
            @(negedge clk);
            chk("stream_in_ready", {31'd0, bus.in_ready}, 32'd1);
            tick();
            if (s) begin
                chk("stream_out2_valid", {31'd0, bus.out2_valid}, 32'd1);
                chk("stream_out2_data", bus.out2_data, d);
            end else begin
                chk("stream_out1_valid", {31'd0, bus.out1_valid}, 32'd1);
                chk("stream_out1_data", bus.out1_data, d);
            end
        end
        bus.in_valid = 1'b0;
        tick();
        tick();
        chk("stream_cnt1", {16'd0, cnt1}, {16'd0, cexp(5)});
        chk("stream_cnt2", {16'd0, cnt2}, {16'd0, cexp(5)});

        // Simultaneous drain and fill on sink 2
        bus.out2_ready = 1'b0;
        send(32'h00000001, 1'b1);
        chk("fill_out2_valid", {31'd0, bus.out2_valid}, 32'd1);
        bus.out2_ready = 1'b1;
        bus.in_valid   = 1'b1;
        bus.in_data    = 32'h00000002;
        bus.sel        = 1'b1;
        q2.push_back(32'h00000002);
        @(negedge clk);
        chk("df_in_ready", {31'd0, bus.in_ready}, 32'd1);
        tick();
        bus.in_valid = 1'b0;
        chk("df_out2_valid", {31'd0, bus.out2_valid}, 32'd1);
        chk("df_out2_data", bus.out2_data, 32'h00000002);
        chk("df_cnt2", {16'd0, cnt2}, {16'd0, cexp(6)});
        tick();
        bus.out2_ready = 1'b0;
        chk("df_cnt2_after", {16'd0, cnt2}, {16'd0, cexp(7)});
        chk("df_out2_empty", {31'd0, bus.out2_valid}, 32'd0);

        // Reset mid-operation with both sinks full
        bus.out1_ready = 1'b0;
        send(32'h00000003, 1'b0);
        send(32'h00000004, 1'b1);
        chk("pre_rst_out1_valid", {31'd0, bus.out1_valid}, 32'd1);
        chk("pre_rst_out2_valid", {31'd0, bus.out2_valid}, 32'd1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        q1.delete();
        q2.delete();
        #1;
        chk("mid_rst_out1_valid", {31'd0, bus.out1_valid}, 32'd0);
        chk("mid_rst_out2_valid", {31'd0, bus.out2_valid}, 32'd0);
        chk("mid_rst_out1_data", bus.out1_data, 32'd0);
        chk("mid_rst_out2_data", bus.out2_data, 32'd0);
        chk("mid_rst_cnt1", {16'd0, cnt1}, 32'd0);
        chk("mid_rst_cnt2", {16'd0, cnt2}, 32'd0);
        chk("mid_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        bus.in_valid = 1'b1;
        bus.in_data  = 32'hDEADBEEF;
        bus.sel      = 1'b0;
        tick();
        chk("rst_no_accept", {31'd0, bus.out1_valid}, 32'd0);
        bus.in_valid = 1'b0;
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        tick();

        // Counter wrap: 65537 deliveries on sink 1
        bus.out1_ready = 1'b1;
        bus.out2_ready = 1'b0;
        bus.sel        = 1'b0;
        for (int i = 0; i < 65537; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 32'(i);
            q1.push_back(32'(i));
            tick();
        end
        bus.in_valid = 1'b0;
        tick();
        tick();
        chk("wrap_cnt1", {16'd0, cnt1}, {16'd0, cexp(1)});
        chk("wrap_cnt2", {16'd0, cnt2}, 32'd0);
        chk("wrap_out1_valid", {31'd0, bus.out1_valid}, 32'd0);

        for (int n = 0; n < 50 && (q1.size() + q2.size()) != 0; n++) tick();
        chk("scoreboard_empty", 32'(q1.size() + q2.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
